// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first,
// with the sum and carry-out returned over a 4-phase req/ack handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             ci,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ack,
    output logic             busy,
    output logic [WIDTH-1:0] r,
    output logic             co
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  xa_r;
    logic [WIDTH-1:0]  yb_r;
    logic              c_r;
    logic [CW-1:0]     cnt_r;
    logic [WIDTH-1:0]  r_r;
    logic              co_r;
    logic              ack_r;
    logic              busy_r;
    logic              sum_s;
    logic              carry_s;
    logic [WIDTH:0]    r_cat_s;

    // Next-state decode for the handshake FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req) state_nxt_s = RUN;
                else     state_nxt_s = IDLE;
            end
            RUN: begin
                if (cnt_r == CNT_LAST) state_nxt_s = DONE;
                else                   state_nxt_s = RUN;
            end
            DONE: begin
                // req must fall before another transaction can start
                if (!req) state_nxt_s = IDLE;
                else      state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Full-adder cell; the new sum bit enters the result from the MSB end
    always_comb begin
        sum_s   = fa_sum(xa_r[0], yb_r[0], c_r);
        carry_s = fa_carry(xa_r[0], yb_r[0], c_r);
        r_cat_s = {sum_s, r_r};
    end

    // State register with handshake outputs decoded one edge ahead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ack_r   <= (state_nxt_s == DONE);
            busy_r  <= (state_nxt_s == RUN);
        end
    end

    // Operand capture and bit-serial datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xa_r  <= '0;
            yb_r  <= '0;
            c_r   <= 1'b0;
            cnt_r <= '0;
            r_r   <= '0;
            co_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        xa_r  <= x;
                        yb_r  <= y;
                        c_r   <= ci;
                        cnt_r <= '0;
                    end
                end
                RUN: begin
                    xa_r  <= xa_r >> 1'b1;
                    yb_r  <= yb_r >> 1'b1;
                    c_r   <= carry_s;
                    r_r   <= r_cat_s[WIDTH:1];
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) co_r <= carry_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign ack  = ack_r;
    assign busy = busy_r;
    assign r    = r_r;
    assign co   = co_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req8 = 1'b0, ci8 = 1'b0;
    logic [7:0] x8 = 8'h00, y8 = 8'h00;
    logic       ack8, busy8, co8;
    logic [7:0] r8;

    logic       req1 = 1'b0, ci1 = 1'b0;
    logic [0:0] x1 = 1'b0, y1 = 1'b0;
    logic       ack1, busy1, co1;
    logic [0:0] r1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .req(req8), .ci(ci8), .x(x8), .y(y8),
        .ack(ack8), .busy(busy8), .r(r8), .co(co8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .ci(ci1), .x(x1), .y(y1),
        .ack(ack1), .busy(busy1), .r(r1), .co(co1)
    );

    // Drive one 8-bit transaction up to ack; req is left high
    task automatic run8(input logic [7:0] xa, input logic [7:0] yb, input logic c,
                        output logic [7:0] res, output logic cout, output int lat,
                        output logic busy_first);
        @(negedge clk);
        x8 = xa; y8 = yb; ci8 = c; req8 = 1'b1;
        @(posedge clk); #1;
        busy_first = busy8;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ack8) begin
                lat = i;
                break;
            end
        end
        res = r8; cout = co8;
    endtask

    task automatic release8();
        @(negedge clk);
        req8 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ack8, busy8, r8, co8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_w8: ack=%b busy=%b r=%h co=%b, required all zero", ack8, busy8, r8, co8);
        end
        checks++;
        if ({ack1, busy1, r1, co1} !== 4'd0) begin
            errors++;
            $display("FAIL reset_w1: ack=%b busy=%b r=%b co=%b, required all zero", ack1, busy1, r1, co1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] res; logic cout, bf; int lat;
        run8(8'h5A, 8'h3C, 1'b0, res, cout, lat, bf);
        checks++;
        if (bf !== 1'b1) begin errors++; $display("FAIL basic_busy: busy=%b, required 1", bf); end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: %0d edges, required 8", lat); end
        checks++;
        if ({cout, res} !== 9'h096) begin errors++; $display("FAIL basic_sum: co=%b r=%h, required co=0 r=96", cout, res); end
        checks++;
        if (busy8 !== 1'b0) begin errors++; $display("FAIL basic_busy_done: busy=%b, required 0", busy8); end
        release8();
        checks++;
        if (ack8 !== 1'b0) begin errors++; $display("FAIL basic_ack_release: ack=%b, required 0", ack8); end
    endtask

    task automatic test_carry();
        logic [7:0] res; logic cout, bf; int lat;
        run8(8'hFF, 8'h01, 1'b0, res, cout, lat, bf);
        checks++;
        if ({cout, res} !== 9'h100) begin errors++; $display("FAIL carry_ff_01: co=%b r=%h, required co=1 r=00", cout, res); end
        release8();
        run8(8'hFF, 8'hFF, 1'b1, res, cout, lat, bf);
        checks++;
        if ({cout, res} !== 9'h1FF) begin errors++; $display("FAIL carry_ff_ff_ci: co=%b r=%h, required co=1 r=ff", cout, res); end
        release8();
        run8(8'h80, 8'h80, 1'b1, res, cout, lat, bf);
        checks++;
        if ({cout, res} !== 9'h101) begin errors++; $display("FAIL carry_80_80_ci: co=%b r=%h, required co=1 r=01", cout, res); end
        release8();
        run8(8'h00, 8'h00, 1'b1, res, cout, lat, bf);
        checks++;
        if ({cout, res} !== 9'h001) begin errors++; $display("FAIL carry_ci_only: co=%b r=%h, required co=0 r=01", cout, res); end
        release8();
    endtask

    task automatic test_width1();
        // Full-adder truth table indexed by {ci,x,y}: {co,r}
        logic [1:0] fa_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        int lat;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ci1 = k[2]; x1 = k[1]; y1 = k[0]; req1 = 1'b1;
            @(posedge clk); #1;
            lat = 0;
            for (int i = 1; i <= 10; i++) begin
                @(posedge clk); #1;
                if (ack1) begin lat = i; break; end
            end
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL w1_latency[%0d]: %0d edges, required 1", k, lat); end
            checks++;
            if ({co1, r1} !== fa_tab[k]) begin
                errors++;
                $display("FAIL w1_sum[%0d]: co=%b r=%b, required co=%b r=%b", k, co1, r1, fa_tab[k][1], fa_tab[k][0]);
            end
            @(negedge clk);
            req1 = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic test_midrun_reset();
        logic [7:0] res; logic cout, bf; int lat;
        @(negedge clk);
        x8 = 8'hA5; y8 = 8'h5A; ci8 = 1'b1; req8 = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({ack8, busy8, r8, co8} !== 11'd0) begin
            errors++;
            $display("FAIL midrun_reset: ack=%b busy=%b r=%h co=%b, required all zero", ack8, busy8, r8, co8);
        end
        req8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run8(8'h12, 8'h34, 1'b1, res, cout, lat, bf);
        checks++;
        if ({cout, res} !== 9'h047 || lat !== 8) begin
            errors++;
            $display("FAIL after_reset_sum: co=%b r=%h lat=%0d, required co=0 r=47 lat=8", cout, res, lat);
        end
        release8();
    endtask

    task automatic test_ignore_inputs();
        int lat;
        @(negedge clk);
        x8 = 8'hC3; y8 = 8'h7E; ci8 = 1'b1; req8 = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            x8 = 8'h00; y8 = 8'h00; ci8 = 1'b0;
            @(posedge clk); #1;
            if (ack8) begin lat = i; break; end
        end
        checks++;
        if ({co8, r8} !== 9'h142 || lat !== 8) begin
            errors++;
            $display("FAIL ignore_inputs: co=%b r=%h lat=%0d, required co=1 r=42 lat=8", co8, r8, lat);
        end
        release8();
    endtask

    task automatic test_no_restart();
        logic [7:0] res; logic cout, bf; int lat;
        run8(8'h0F, 8'h01, 1'b0, res, cout, lat, bf);
        checks++;
        if ({cout, res} !== 9'h010) begin errors++; $display("FAIL hold_sum: co=%b r=%h, required co=0 r=10", cout, res); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({ack8, busy8, co8, r8} !== 11'b1_0_0_00010000) begin
                errors++;
                $display("FAIL hold_done[%0d]: ack=%b busy=%b co=%b r=%h, required ack=1 busy=0 co=0 r=10", i, ack8, busy8, co8, r8);
            end
        end
        release8();
        checks++;
        if (ack8 !== 1'b0) begin errors++; $display("FAIL hold_release: ack=%b, required 0", ack8); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy8, co8, r8} !== 10'b0_0_00010000) begin
            errors++;
            $display("FAIL idle_hold: busy=%b co=%b r=%h, required busy=0 co=0 r=10", busy8, co8, r8);
        end
    endtask

    task automatic test_req_at_reset_release();
        int lat;
        @(negedge clk);
        rst = 1'b1;
        x8 = 8'h77; y8 = 8'h11; ci8 = 1'b0; req8 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ack8) begin lat = i; break; end
        end
        checks++;
        if ({co8, r8} !== 9'h088 || lat !== 9) begin
            errors++;
            $display("FAIL req_at_release: co=%b r=%h edges=%0d, required co=0 r=88 edges=9", co8, r8, lat);
        end
        release8();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_width1();
        test_midrun_reset();
        test_ignore_inputs();
        test_no_restart();
        test_req_at_reset_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
